// File: rtl/dvs_fifo_pkg.sv
// Shared types and default widths for the event FIFO slice.
package dvs_fifo_pkg;

  typedef enum logic {IRQ_IDLE, IRQ_ACTIVE} irq_state_e;

  localparam int unsigned FIFO_DWIDTH = 24;
  localparam int unsigned FIFO_AWIDTH = 10;
  localparam int unsigned FIFO_CWIDTH = 16;

endpackage

// File: rtl/event_fifo_irq_if.sv
// Push/pop handshake between the event front-end, the FIFO and the register file.
interface event_fifo_irq_if #(
  parameter int unsigned DWIDTH = 24
);
  logic              wr_valid;
  logic [DWIDTH-1:0] wr_data;
  logic              wr_ready;
  logic              fifo_rd_en;
  logic [DWIDTH-1:0] rd_data;
  logic              rd_valid;

  modport master (
    output wr_valid, wr_data, fifo_rd_en,
    input  wr_ready, rd_data, rd_valid
  );

  modport slave (
    input  wr_valid, wr_data, fifo_rd_en,
    output wr_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/event_fifo_mem.sv
// Simple dual-port storage with asynchronous read; kept separate so an SRAM macro can drop in.
module event_fifo_mem #(
  parameter int unsigned DWIDTH = 24,
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);
  localparam int unsigned Depth = 2 ** AWIDTH;

  logic [DWIDTH-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/event_fifo_irq.sv
// Event FIFO with registered occupancy, drop statistics and a hysteretic interrupt.
// Optional high-water mark output enabled by defining EVENT_FIFO_HWM_EN.
module event_fifo_irq
  import dvs_fifo_pkg::*;
#(
  parameter int unsigned DWIDTH = FIFO_DWIDTH,
  parameter int unsigned AWIDTH = FIFO_AWIDTH,
  parameter int unsigned CWIDTH = FIFO_CWIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fifo_rst_n,
  event_fifo_irq_if.slave    bus,
  output logic [AWIDTH:0]    fifo_numel,
  input  logic [AWIDTH:0]    irq_assert_thresh,
  input  logic [AWIDTH:0]    irq_deassert_thresh,
  output logic               irq,
  output logic               overflow,
  output logic [CWIDTH-1:0]  drop_cnt,
`ifdef EVENT_FIFO_HWM_EN
  output logic [AWIDTH:0]    hwm,
`endif
  input  logic               clr_stats
);
  localparam logic [AWIDTH:0] Depth = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH-1:0] wptr_q, rptr_q;
  logic [AWIDTH:0]   numel_q, numel_d;
  logic              overflow_q;
  logic [CWIDTH-1:0] drop_cnt_q;
  irq_state_e        irq_state_q;
  logic              full, empty, push, pop, drop;

  assign full  = (numel_q == Depth);
  assign empty = (numel_q == '0);

  // wr_ready depends only on registered occupancy, so a pop never frees room in the same cycle.
  assign bus.wr_ready = !full;
  assign bus.rd_valid = !empty;

  assign push = fifo_rst_n && bus.wr_valid && !full;
  assign pop  = fifo_rst_n && bus.fifo_rd_en && !empty;
  assign drop = fifo_rst_n && bus.wr_valid && full;

  always_comb begin
    numel_d = numel_q;
    unique case ({push, pop})
      2'b10:   numel_d = numel_q + (AWIDTH + 1)'(1);
      2'b01:   numel_d = numel_q - (AWIDTH + 1)'(1);
      default: numel_d = numel_q;
    endcase
  end

  event_fifo_mem #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wptr_q),
    .wdata (bus.wr_data),
    .raddr (rptr_q),
    .rdata (bus.rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      numel_q <= '0;
    end else if (!fifo_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      numel_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AWIDTH'(1);
      if (pop)  rptr_q <= rptr_q + AWIDTH'(1);
      numel_q <= numel_d;
    end
  end

  // A drop coinciding with clr_stats restarts the statistics at one drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (!fifo_rst_n) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clr_stats) begin
        drop_cnt_q <= CWIDTH'(1);
      end else if (drop_cnt_q != {CWIDTH{1'b1}}) begin
        drop_cnt_q <= drop_cnt_q + CWIDTH'(1);
      end
    end else if (clr_stats) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end
  end

  // Evaluated on registered occupancy, so irq trails fifo_numel by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_state_q <= IRQ_IDLE;
    end else if (!fifo_rst_n) begin
      irq_state_q <= IRQ_IDLE;
    end else begin
      unique case (irq_state_q)
        IRQ_IDLE: begin
          if (irq_assert_thresh != '0 && numel_q >= irq_assert_thresh) begin
            irq_state_q <= IRQ_ACTIVE;
          end
        end
        IRQ_ACTIVE: begin
          if (numel_q <= irq_deassert_thresh || irq_assert_thresh == '0) begin
            irq_state_q <= IRQ_IDLE;
          end
        end
        default: irq_state_q <= IRQ_IDLE;
      endcase
    end
  end

`ifdef EVENT_FIFO_HWM_EN
  logic [AWIDTH:0] hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hwm_q <= '0;
    end else if (!fifo_rst_n || clr_stats) begin
      hwm_q <= '0;
    end else if (numel_q > hwm_q) begin
      hwm_q <= numel_q;
    end
  end

  assign hwm = hwm_q;
`endif

  assign fifo_numel = numel_q;
  assign irq        = (irq_state_q == IRQ_ACTIVE);
  assign overflow   = overflow_q;
  assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_event_fifo_irq.sv
// Directed self-checking bench for event_fifo_irq at DWIDTH=8, AWIDTH=3, CWIDTH=4.
module tb_event_fifo_irq;
  logic       clk;
  logic       rst_n;
  logic       fifo_rst_n;
  logic       clr_stats;
  logic [3:0] fifo_numel;
  logic [3:0] at;
  logic [3:0] dt;
  logic       irq;
  logic       overflow;
  logic [3:0] drop_cnt;
  int         checks;
  int         failures;

  event_fifo_irq_if #(.DWIDTH(8)) bus ();

  event_fifo_irq #(
    .DWIDTH (8),
    .AWIDTH (3),
    .CWIDTH (4)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .fifo_rst_n          (fifo_rst_n),
    .bus                 (bus),
    .fifo_numel          (fifo_numel),
    .irq_assert_thresh   (at),
    .irq_deassert_thresh (dt),
    .irq                 (irq),
    .overflow            (overflow),
    .drop_cnt            (drop_cnt),
    .clr_stats           (clr_stats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: apply inputs, pass the edge, settle 1 time unit after it.
  task automatic step(input logic wv, input logic [7:0] wd, input logic re);
    bus.wr_valid   = wv;
    bus.wr_data    = wd;
    bus.fifo_rd_en = re;
    @(posedge clk);
    #1;
    bus.wr_valid   = 1'b0;
    bus.fifo_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (fifo_numel !== 4'd0 || bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1 ||
        irq !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL reset: numel=%0d rd_valid=%b wr_ready=%b irq=%b ovf=%b drop=%0d, need 0 0 1 0 0 0",
               fifo_numel, bus.rd_valid, bus.wr_ready, irq, overflow, drop_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h11 + i), 1'b0);
    checks++;
    if (fifo_numel !== 4'd8 || bus.wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill: numel=%0d wr_ready=%b, need 8 0", fifo_numel, bus.wr_ready);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(8'h11 + i)) begin
        failures++;
        $display("FAIL drain[%0d]: rd_valid=%b rd_data=%h, need 1 %h",
                 i, bus.rd_valid, bus.rd_data, 8'(8'h11 + i));
      end
      step(1'b0, 8'h00, 1'b1);
    end
    checks++;
    if (bus.rd_valid !== 1'b0 || fifo_numel !== 4'd0) begin
      failures++;
      $display("FAIL drained: rd_valid=%b numel=%0d, need 0 0", bus.rd_valid, fifo_numel);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (fifo_numel !== 4'd0 || bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL pop_empty: numel=%0d rd_valid=%b, need 0 0", fifo_numel, bus.rd_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'hFF, 1'b0);
      if (i == 0) begin
        checks++;
        if (overflow !== 1'b1 || drop_cnt !== 4'd1) begin
          failures++;
          $display("FAIL first_drop: ovf=%b drop=%0d, need 1 1", overflow, drop_cnt);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 4'd15 || fifo_numel !== 4'd8) begin
      failures++;
      $display("FAIL saturate: ovf=%b drop=%0d numel=%0d, need 1 15 8",
               overflow, drop_cnt, fifo_numel);
    end
    clr_stats = 1'b1;
    step(1'b1, 8'hFF, 1'b0);
    clr_stats = 1'b0;
    checks++;
    if (overflow !== 1'b1 || drop_cnt !== 4'd1) begin
      failures++;
      $display("FAIL clr_with_drop: ovf=%b drop=%0d, need 1 1", overflow, drop_cnt);
    end
    clr_stats = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    clr_stats = 1'b0;
    checks++;
    if (overflow !== 1'b0 || drop_cnt !== 4'd0) begin
      failures++;
      $display("FAIL clr_stats: ovf=%b drop=%0d, need 0 0", overflow, drop_cnt);
    end
    checks++;
    if (bus.rd_data !== 8'h00) begin
      failures++;
      $display("FAIL head_after_drops: rd_data=%h, need 00", bus.rd_data);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_irq();
    at = 4'd6;
    dt = 4'd2;
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
    checks++;
    if (fifo_numel !== 4'd6 || irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_lag: numel=%0d irq=%b, need 6 0", fifo_numel, irq);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_rise: irq=%b, need 1", irq);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (fifo_numel !== 4'd3 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_hold: numel=%0d irq=%b, need 3 1", fifo_numel, irq);
    end
    step(1'b0, 8'h00, 1'b1);
    checks++;
    if (fifo_numel !== 4'd2 || irq !== 1'b1) begin
      failures++;
      $display("FAIL irq_fall_lag: numel=%0d irq=%b, need 2 1", fifo_numel, irq);
    end
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_fall: irq=%b, need 0", irq);
    end
    at = 4'd0;
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h50 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (fifo_numel !== 4'd7 || irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_disabled: numel=%0d irq=%b, need 7 0", fifo_numel, irq);
    end
    at = 4'd6;
    step(1'b0, 8'h00, 1'b0);
    at = 4'd0;
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL irq_disable_active: irq=%b, need 0", irq);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    dt = 4'd0;
  endtask

  task automatic test_simultaneous();
    step(1'b1, 8'hA5, 1'b1);
    checks++;
    if (fifo_numel !== 4'd1 || bus.rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL pushpop_empty: numel=%0d rd_data=%h, need 1 a5", fifo_numel, bus.rd_data);
    end
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);
    checks++;
    if (fifo_numel !== 4'd7 || drop_cnt !== 4'd1 || bus.rd_data !== 8'h21) begin
      failures++;
      $display("FAIL pushpop_full: numel=%0d drop=%0d rd_data=%h, need 7 1 21",
               fifo_numel, drop_cnt, bus.rd_data);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    clr_stats = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    clr_stats = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'h34, 1'b1);
    checks++;
    if (fifo_numel !== 4'd4) begin
      failures++;
      $display("FAIL pushpop_half: numel=%0d, need 4", fifo_numel);
    end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (bus.rd_data !== 8'(8'h30 + i)) begin
        failures++;
        $display("FAIL half_order[%0d]: rd_data=%h, need %h", i, bus.rd_data, 8'(8'h30 + i));
      end
      step(1'b0, 8'h00, 1'b1);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 8'h00, 1'b0);
    for (int i = 1; i < 20; i++) begin
      checks++;
      if (bus.rd_data !== 8'(i - 1) || fifo_numel !== 4'd1) begin
        failures++;
        $display("FAIL wrap[%0d]: rd_data=%h numel=%0d, need %h 1",
                 i, bus.rd_data, fifo_numel, 8'(i - 1));
      end
      step(1'b1, 8'(i), 1'b1);
    end
    checks++;
    if (bus.rd_data !== 8'h13) begin
      failures++;
      $display("FAIL wrap_last: rd_data=%h, need 13", bus.rd_data);
    end
    step(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset_mid();
    at = 4'd4;
    dt = 4'd1;
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    checks++;
    if (fifo_numel !== 4'd5 || irq !== 1'b1 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL pre_soft: numel=%0d irq=%b ovf=%b, need 5 1 1", fifo_numel, irq, overflow);
    end
    fifo_rst_n = 1'b0;
    step(1'b1, 8'h77, 1'b0);
    fifo_rst_n = 1'b1;
    checks++;
    if (fifo_numel !== 4'd0 || irq !== 1'b0 || overflow !== 1'b0 || drop_cnt !== 4'd0 ||
        bus.rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL soft_reset: numel=%0d irq=%b ovf=%b drop=%0d rd_valid=%b, need 0 0 0 0 0",
               fifo_numel, irq, overflow, drop_cnt, bus.rd_valid);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.rd_data !== 8'h70 || irq !== 1'b1) begin
      failures++;
      $display("FAIL post_soft: rd_data=%h irq=%b, need 70 1", bus.rd_data, irq);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_numel !== 4'd0 || irq !== 1'b0 || bus.rd_valid !== 1'b0 || bus.wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL async_reset: numel=%0d irq=%b rd_valid=%b wr_ready=%b, need 0 0 0 1",
               fifo_numel, irq, bus.rd_valid, bus.wr_ready);
    end
    #1;
    rst_n = 1'b1;
    at = 4'd0;
    dt = 4'd0;
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    fifo_rst_n     = 1'b1;
    clr_stats      = 1'b0;
    at             = 4'd0;
    dt             = 4'd0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = 8'h00;
    bus.fifo_rd_en = 1'b0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_irq();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
